// File: rtl/sram_bank_ctrl.sv
// WIDTH x DEPTH SRAM bank built from a grid of 512x8 macros, with a valid/ready
// request/response interface, byte strobes, optional output register and zero scrub.

module sram_bank_ctrl #(
   parameter  int WIDTH     = 32,
   parameter  int DEPTH     = 1024,
   parameter  int OUT_REG   = 0,
   parameter  int INIT_ZERO = 1,
   localparam int ADDR_W    = $clog2(DEPTH),
   localparam int NB        = WIDTH / 8
) (
`ifdef USE_POWER_PINS
   inout  wire                VDD,
   inout  wire                VSS,
`endif
   input  logic               CLK,
   input  logic               RST,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_we,
   input  logic [NB-1:0]      req_wstrb,
   input  logic [ADDR_W-1:0]  req_addr,
   input  logic [WIDTH-1:0]   req_wdata,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_we,
   output logic [WIDTH-1:0]   rsp_rdata,
   output logic               init_done
);

   localparam int ROWS      = DEPTH / 512;
   localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int LAT       = 1 + OUT_REG;
   localparam int RSP_DEPTH = LAT + 1;
   localparam int PTR_W     = $clog2(RSP_DEPTH);
   localparam int CNT_W     = $clog2(RSP_DEPTH + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SCRUB, ST_RUN} state_t;

   state_t             state_reg;
   logic [8:0]         scrub_cnt_reg;
   logic               init_done_reg;

   logic               scrub_active;
   logic               accept;
   logic               pop;
   logic [ROW_W-1:0]   req_row;

   logic [ROWS-1:0]            row_cen;
   logic                       mac_gwen;
   logic [8:0]                 mac_a;
   logic [NB-1:0][7:0]         mac_wen;
   logic [NB-1:0][7:0]         mac_d;
   logic [ROWS-1:0][WIDTH-1:0] row_q;

   logic               s1_valid_reg;
   logic               s1_we_reg;
   logic [ROW_W-1:0]   s1_row_reg;
   logic [WIDTH-1:0]   s1_data;

   logic               fin_valid;
   logic               fin_we;
   logic [WIDTH-1:0]   fin_data;
   logic [1:0]         inflight;

   logic [WIDTH-1:0]     fifo_data_reg [RSP_DEPTH];
   logic [RSP_DEPTH-1:0] fifo_we_reg;
   logic [PTR_W-1:0]     rd_ptr_reg;
   logic [PTR_W-1:0]     wr_ptr_reg;
   logic [CNT_W-1:0]     fifo_cnt_reg;
   logic                 fifo_empty;
   logic                 push;
   logic                 fifo_pop;
   logic [WIDTH-1:0]     head_data;
   logic                 head_we;
   logic [3:0]           occ;

   genvar gi, gj;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg     <= ST_IDLE;
         scrub_cnt_reg <= '0;
         init_done_reg <= (INIT_ZERO == 0);
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (INIT_ZERO != 0) begin
                  state_reg <= ST_SCRUB;
               end else begin
                  state_reg     <= ST_RUN;
                  init_done_reg <= 1'b1;
               end
            end
            ST_SCRUB: begin
               scrub_cnt_reg <= scrub_cnt_reg + 9'd1;
               if (scrub_cnt_reg == 9'd511) begin
                  state_reg     <= ST_RUN;
                  init_done_reg <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign init_done    = init_done_reg;
   assign scrub_active = (state_reg == ST_SCRUB) && !RST;

   // A pop frees a slot in the same cycle, so a full pipeline still streams.
   assign occ       = 4'(fifo_cnt_reg) + 4'(inflight);
   assign req_ready = !RST && (state_reg == ST_RUN) &&
                      ((occ < 4'(RSP_DEPTH)) || (rsp_valid && rsp_ready));
   assign accept    = req_valid && req_ready;

   generate
      if (ROWS > 1) begin : g_row_dec
         assign req_row = req_addr[ADDR_W-1:9];
      end else begin : g_row_one
         assign req_row = '0;
      end
   endgenerate

   assign mac_a    = scrub_active ? scrub_cnt_reg : req_addr[8:0];
   assign mac_gwen = scrub_active ? 1'b0 : !req_we;
   assign mac_d    = scrub_active ? '0 : req_wdata;

   generate
      for (gi = 0; gi < NB; gi++) begin : g_lane
         assign mac_wen[gi] = (scrub_active || (req_we && req_wstrb[gi])) ? 8'h00 : 8'hFF;
      end

      for (gi = 0; gi < ROWS; gi++) begin : g_row
         assign row_cen[gi] = !(scrub_active || (accept && (req_row == ROW_W'(gi))));
         for (gj = 0; gj < NB; gj++) begin : g_col
            gf180mcu_fd_ip_sram__sram512x8m8wm1_wrapper u_mac (
`ifdef USE_POWER_PINS
               .VDD  (VDD),
               .VSS  (VSS),
`endif
               .CLK  (CLK),
               .CEN  (row_cen[gi]),
               .GWEN (mac_gwen),
               .WEN  (mac_wen[gj]),
               .A    (mac_a),
               .D    (mac_d[gj]),
               .Q    (row_q[gi][gj*8 +: 8])
            );
         end
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_valid_reg <= 1'b0;
         s1_we_reg    <= 1'b0;
         s1_row_reg   <= '0;
      end else begin
         s1_valid_reg <= accept;
         s1_we_reg    <= req_we;
         s1_row_reg   <= req_row;
      end
   end

   // Q is only meaningful the cycle after a read to that row.
   assign s1_data = (s1_valid_reg && !s1_we_reg) ? row_q[s1_row_reg] : '0;

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic             s2_valid_reg;
         logic             s2_we_reg;
         logic [WIDTH-1:0] s2_data_reg;

         always_ff @(posedge CLK) begin
            if (RST) begin
               s2_valid_reg <= 1'b0;
               s2_we_reg    <= 1'b0;
               s2_data_reg  <= '0;
            end else begin
               s2_valid_reg <= s1_valid_reg;
               s2_we_reg    <= s1_we_reg;
               s2_data_reg  <= s1_data;
            end
         end

         assign fin_valid = s2_valid_reg;
         assign fin_we    = s2_we_reg;
         assign fin_data  = s2_data_reg;
         assign inflight  = {1'b0, s1_valid_reg} + {1'b0, s2_valid_reg};
      end else begin : g_noreg
         assign fin_valid = s1_valid_reg;
         assign fin_we    = s1_we_reg;
         assign fin_data  = s1_data;
         assign inflight  = {1'b0, s1_valid_reg};
      end
   endgenerate

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Response FIFO with fall-through: the pipeline tail bypasses it when empty.
   assign fifo_empty = (fifo_cnt_reg == '0);
   assign head_data  = fifo_empty ? fin_data : fifo_data_reg[rd_ptr_reg];
   assign head_we    = fifo_empty ? fin_we   : fifo_we_reg[rd_ptr_reg];
   assign rsp_valid  = !fifo_empty || fin_valid;
   assign pop        = rsp_valid && rsp_ready;
   assign fifo_pop   = pop && !fifo_empty;
   assign push       = fin_valid && !(fifo_empty && rsp_ready);
   assign rsp_rdata  = rsp_valid ? head_data : '0;
   assign rsp_we     = rsp_valid && head_we;

   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         fifo_cnt_reg <= '0;
      end else begin
         if (push) begin
            fifo_data_reg[wr_ptr_reg] <= fin_data;
            fifo_we_reg[wr_ptr_reg]   <= fin_we;
            wr_ptr_reg                <= ptr_inc(wr_ptr_reg);
         end
         if (fifo_pop) begin
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         end
         fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(push) - CNT_W'(fifo_pop);
      end
   end

endmodule

// Behavioural stand-in for the 512x8 macro: active-low enables, per-bit write mask.
module gf180mcu_fd_ip_sram__sram512x8m8wm1_wrapper (
`ifdef USE_POWER_PINS
   inout  wire        VDD,
   inout  wire        VSS,
`endif
   input  logic       CLK,
   input  logic       CEN,
   input  logic       GWEN,
   input  logic [7:0] WEN,
   input  logic [8:0] A,
   input  logic [7:0] D,
   output logic [7:0] Q
);

   logic [7:0] mem [512];

   always_ff @(posedge CLK) begin
      if (!CEN) begin
         if (!GWEN) begin
            mem[A] <= (mem[A] & WEN) | (D & ~WEN);
         end else begin
            Q <= mem[A];
         end
      end
   end

endmodule

// File: doc/sram_bank_ctrl.md
Name: sram_bank_ctrl

Overview:
- Parametrised successor to the single 512x8 macro wrapper: a WIDTH x DEPTH SRAM bank.
- Built as a grid of gf180mcu_fd_ip_sram__sram512x8m8wm1_wrapper instances: COLS=WIDTH/8 byte lanes by ROWS=DEPTH/512 rows.
- Adds a valid/ready request/response interface, per-byte write strobes, an optional output register, response backpressure with credit-based flow control, and an optional post-reset zero-scrub FSM.
- Sits between the SoC bus/cache fill logic and the macros, on-chip scratchpad/cache data store.

Parameters:
- WIDTH, 32, data width in bits; multiple of 8, at least 8.
- DEPTH, 1024, words; 512*2^k, k>=0.
- OUT_REG, 0, 1 adds a registered output stage (+1 cycle latency).
- INIT_ZERO, 1, 1 enables the post-reset scrub writing zero to every word.
- Derived: ADDR_W=clog2(DEPTH), NB=WIDTH/8, LAT=1+OUT_REG, RSP_DEPTH=LAT+1.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous active-high reset.
- VDD/VSS  inout  1  only under USE_POWER_PINS; passed to every macro.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid&&req_ready.
- req_we  in  1  1=write, 0=read.
- req_wstrb  in  NB  byte write enables, active-high.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  WIDTH  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready.
- rsp_we  out  1  echo of req_we for this response.
- rsp_rdata  out  WIDTH  read data; 0 for write responses.
- init_done  out  1  high once the bank is usable.

Behaviour:
- Reset (RST sampled high): req_ready=0, rsp_valid=0, rsp_we=0, rsp_rdata=0. init_done=0 if INIT_ZERO else 1. Credits, FIFO, pipeline and FSM cleared. All macros driven CEN=1.
- Reset mid-scrub or mid-traffic: in-flight and buffered responses are discarded; scrub restarts from address 0.
- FSM states:
  - IDLE: after reset. Goes to SCRUB if INIT_ZERO, else RUN.
  - SCRUB: 9-bit counter 0..511. All macros selected with CEN=0, GWEN=0, WEN=0x00, D=0, A=counter. Goes to RUN after counter 511. req_ready=0 throughout.
  - RUN: normal operation; init_done=1 from the first RUN cycle, exactly 513 cycles after RST deasserts when INIT_ZERO=1.
- Address decode:
  - row = req_addr[ADDR_W-1:9]; macro A = req_addr[8:0].
  - Only the selected row's macros get CEN=0; all other rows CEN=1. Unused rows never clock data.
- Write: GWEN=0; lane i WEN=8'h00 if req_wstrb[i], else 8'hFF. wstrb=0 is a legal no-op write that still returns a response.
- Read: GWEN=1, WEN=8'hFF.
- Macro Q is undefined except on the cycle after a read to that row. The row index of each read is registered and used to mux Q in that cycle only; Q is never sampled at any other time.
- Latency:
  - Accept in cycle N; macro samples at the end of N; Q is valid in N+1.
  - Response reaches the FIFO head with rsp_valid in N+LAT when the FIFO is empty.
- Ordering: responses are returned in request order, reads and writes alike.
- Flow control:
  - occ = in-flight + FIFO entries, at most RSP_DEPTH.
  - req_ready = RUN && (occ < RSP_DEPTH || (rsp_valid && rsp_ready)).
  - Sustains 1 request per cycle while rsp_ready=1.
  - rsp_ready=0 stalls acceptance after RSP_DEPTH outstanding; data is never lost or duplicated.
- rsp_valid is held, and rsp_rdata/rsp_we stay stable, until the response is taken.
- Read-after-write to the same address in consecutive cycles returns the new data; macro write completes before the next read edge.
- Simultaneous accept and pop in the same cycle: occ is unchanged.

Test Plan:
- Reset, INIT_ZERO=1 -> init_done rises 513 cycles after RST falls. Then read addr 0x3FF -> rsp_rdata=0x00000000, rsp_we=0, rsp_valid exactly 1 cycle after accept.
- Write 0x0200 data 0xDEADBEEF wstrb 0xF, then write 0x0200 data 0x11223344 wstrb 0x5, then read 0x0200 -> 0xDE22BE44. Row 1 is active; row 0 macros show CEN=1 throughout.
- Back-to-back reads of 0x000..0x00F with rsp_ready=1 -> req_ready stays 1, 16 in-order responses on consecutive cycles. Repeat with OUT_REG=1 -> same data with latency 2.
- Stream reads while holding rsp_ready=0 -> req_ready drops after exactly RSP_DEPTH (2) accepts. Releasing rsp_ready delivers both responses in order with no loss.
- Assert RST at scrub count 200 -> scrub restarts at 0, init_done after a further 513 cycles. Assert RST with 2 responses pending -> rsp_valid=0 next cycle, and no stale responses appear afterwards.
- WIDTH=8, DEPTH=512, INIT_ZERO=0 -> init_done=1 immediately after reset; write then read 0x1FF with data 0xA5 -> 0xA5.
